// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared constants, address-width helper and request type for mem_arb
package mem_arb_pkg;

    localparam int DEF_DEPTH    = 32;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 2;

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DEF_AW = calc_aw(DEF_DEPTH);

    typedef struct packed {
        logic                 write;
        logic [DEF_AW-1:0]    addr;
        logic [DEF_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_rr_arbiter.sv
// rtl/mem_arb_rr_arbiter.sv - round-robin arbiter: owns the priority pointer, one-hot grant
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] gnt_idx_o,
    output logic          gnt_any_o
);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] cand;
    logic          found;

    // Scan from ptr upward with wrap; the first requester wins.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int off = 0; off < N; off++) begin
            cand = PW'((int'(ptr_q) + off) % N);
            if (!found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                gnt_idx_o   = cand;
                found       = 1'b1;
            end
        end
        if (rst) begin
            gnt_o = '0;
            found = 1'b0;
        end
        gnt_any_o = found;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (gnt_idx_o == PW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - multi-channel arbitrated single-port word array with registered read data
// Optional even-parity protection of stored words when MEM_ARB_PARITY_EN is defined.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int AW       = calc_aw(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS-1:0]       write,
    input  logic [CHANNELS*AW-1:0]    addr,
    input  logic [CHANNELS*WIDTH-1:0] wdata,
    output logic [CHANNELS-1:0]       gnt,
    output logic [CHANNELS-1:0]       rvalid,
    output logic [WIDTH-1:0]          rdata,
    output logic                      perr
);

    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
`ifdef MEM_ARB_PARITY_EN
    localparam int SW = WIDTH + 1;
`else
    localparam int SW = WIDTH;
`endif

    logic [PW-1:0]       sel;
    logic                gnt_any;
    logic [AW-1:0]       sel_addr;
    logic [WIDTH-1:0]    sel_wdata;
    logic                sel_write;
    logic                in_range;
    logic                wr_en, rd_en;
    logic [SW-1:0]       wword, rword;

    logic [SW-1:0]       mem_q [DEPTH];
    logic [CHANNELS-1:0] rvalid_q, rvalid_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;

    rr_arbiter #(.N(CHANNELS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .gnt_o     (gnt),
        .gnt_idx_o (sel),
        .gnt_any_o (gnt_any)
    );

    always_comb begin
        sel_addr  = addr[int'(sel)*AW +: AW];
        sel_wdata = wdata[int'(sel)*WIDTH +: WIDTH];
        sel_write = write[sel];
        // Only matters for non-power-of-2 DEPTH, where the address space overhangs the array.
        in_range  = (int'(sel_addr) < DEPTH);
        wr_en     = gnt_any & sel_write & in_range;
        rd_en     = gnt_any & ~sel_write;
`ifdef MEM_ARB_PARITY_EN
        wword     = {^sel_wdata, sel_wdata};
`else
        wword     = sel_wdata;
`endif
        rword     = in_range ? mem_q[sel_addr] : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[sel_addr] <= wword;
        end
    end

    always_comb begin
        rvalid_d = rd_en ? gnt : '0;
        rdata_d  = rd_en ? rword[WIDTH-1:0] : rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;

`ifdef MEM_ARB_PARITY_EN
    logic perr_q, perr_d;

    // A stored word with odd total parity has been corrupted.
    always_comb begin
        perr_d = rd_en ? ^rword : 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - scoreboard bench for mem_arb (4-channel DEPTH=24 and 2-channel DEPTH=32 instances)
module tb_mem_arb;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [3:0]  a_req, a_write, a_gnt, a_rvalid;
    logic [19:0] a_addr;
    logic [31:0] a_wdata;
    logic [7:0]  a_rdata;
    logic        a_perr;

    logic [1:0]  b_req, b_write, b_gnt, b_rvalid;
    logic [9:0]  b_addr;
    logic [15:0] b_wdata;
    logic [7:0]  b_rdata;
    logic        b_perr;

    mem_arb #(.DEPTH(24), .WIDTH(8), .CHANNELS(4)) dut_a (
        .clk(clk), .rst(rst), .req(a_req), .write(a_write), .addr(a_addr),
        .wdata(a_wdata), .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .perr(a_perr)
    );

    mem_arb #(.DEPTH(32), .WIDTH(8), .CHANNELS(2)) dut_b (
        .clk(clk), .rst(rst), .req(b_req), .write(b_write), .addr(b_addr),
        .wdata(b_wdata), .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .perr(b_perr)
    );

    typedef struct {
        logic [3:0] rv;
        logic [7:0] d;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if ((|a_rvalid) === 1'b1) begin
            if (qa.size() == 0) begin
                check("a_unexpected_rvalid", {28'h0, a_rvalid}, 32'h0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_read", {20'h0, a_rvalid, a_rdata}, {20'h0, e.rv, e.d});
            end
        end
    end

    always @(negedge clk) begin
        if ((|b_rvalid) === 1'b1) begin
            if (qb.size() == 0) begin
                check("b_unexpected_rvalid", {30'h0, b_rvalid}, 32'h0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_read", {20'h0, 2'b00, b_rvalid, b_rdata}, {20'h0, e.rv, e.d});
            end
        end
    end

    // Ops start at posedge+1 and return at posedge+1 after their grant edge.
    task automatic a_op(input int ch, input logic wr, input logic [4:0] ad,
                        input logic [7:0] d, input logic [7:0] exp);
        logic [3:0] eg;
        eg = 4'b0001 << ch;
        a_write[ch]       = wr;
        a_addr[ch*5 +: 5] = ad;
        a_wdata[ch*8 +: 8] = d;
        a_req[ch]         = 1'b1;
        @(negedge clk);
        check("a_gnt", {28'h0, a_gnt}, {28'h0, eg});
        if (!wr) qa.push_back('{eg, exp});
        @(posedge clk); #1;
        a_req[ch] = 1'b0;
    endtask

    task automatic b_op(input int ch, input logic wr, input logic [4:0] ad,
                        input logic [7:0] d, input logic [7:0] exp);
        logic [1:0] eg;
        eg = 2'b01 << ch;
        b_write[ch]        = wr;
        b_addr[ch*5 +: 5]  = ad;
        b_wdata[ch*8 +: 8] = d;
        b_req[ch]          = 1'b1;
        @(negedge clk);
        check("b_gnt", {30'h0, b_gnt}, {30'h0, eg});
        if (!wr) qa_dummy_guard: qb.push_back('{{2'b00, eg}, exp});
        @(posedge clk); #1;
        b_req[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_rd [3];
        exp_rd = '{8'h11, 8'h12, 8'h13};

        rst = 1'b1;
        a_req = 4'hF; a_write = '0; a_addr = '0; a_wdata = '0;
        b_req = 2'b11; b_write = '0; b_addr = '0; b_wdata = '0;
        @(posedge clk); #1;
        check("rst_a_gnt", {28'h0, a_gnt}, 32'h0);
        check("rst_b_gnt", {30'h0, b_gnt}, 32'h0);
        check("rst_a_rvalid", {28'h0, a_rvalid}, 32'h0);
        check("rst_a_rdata", {24'h0, a_rdata}, 32'h0);
        check("rst_b_rdata", {24'h0, b_rdata}, 32'h0);
        check("rst_perr", {30'h0, a_perr, b_perr}, 32'h0);
        a_req = '0;
        b_req = '0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Four writers held high: rotation 0,1,2,3,0,1,2,3.
        a_write = 4'hF;
        a_addr  = {5'd13, 5'd12, 5'd11, 5'd10};
        a_wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        a_req   = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("a_rr_order", {28'h0, a_gnt}, 32'(1) << (k % 4));
        end
        @(posedge clk); #1;
        a_req = '0;

        // DEPTH=24: address 27 is outside the array.
        a_op(0, 1'b1, 5'd3,  8'h5A, 8'h00);
        a_op(0, 1'b1, 5'd27, 8'hFF, 8'h00);
        a_op(0, 1'b0, 5'd27, 8'h00, 8'h00);
        a_op(0, 1'b0, 5'd3,  8'h00, 8'h5A);

        // Three concurrent readers, pointer at 1: granted 1,2,3 on consecutive cycles.
        a_write = '0;
        a_addr  = {5'd13, 5'd12, 5'd11, 5'd0};
        a_req   = 4'b1110;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            check("a_rr_reads", {28'h0, a_gnt}, 32'(1) << k);
            qa.push_back('{4'(4'b0001 << k), exp_rd[k-1]});
            @(posedge clk); #1;
            a_req[k] = 1'b0;
        end

        // Write then read same address on consecutive cycles, latency one.
        b_op(0, 1'b1, 5'd3, 8'hA5, 8'h00);
        b_op(1, 1'b0, 5'd3, 8'h00, 8'hA5);
        @(negedge clk);
        check("b_latency", {30'h0, b_rvalid}, 32'h2);
        @(posedge clk); #1;

        // Same-cycle write ch0 / read ch1 of address 31.
        b_write = 2'b01;
        b_addr  = {5'd31, 5'd31};
        b_wdata = {8'h00, 8'h3C};
        b_req   = 2'b11;
        @(negedge clk);
        check("b_both_first", {30'h0, b_gnt}, 32'h1);
        @(posedge clk); #1;
        b_req[0] = 1'b0;
        @(negedge clk);
        check("b_both_second", {30'h0, b_gnt}, 32'h2);
        qb.push_back('{4'b0010, 8'h3C});
        @(posedge clk); #1;
        b_req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("b_rdata_hold", {22'h0, b_rvalid, b_rdata}, {22'h0, 2'b00, 8'h3C});
        @(posedge clk); #1;

        // Reset while a read is being granted: the read must vanish and ptr return to 0.
        b_op(0, 1'b1, 5'd7, 8'h77, 8'h00);
        b_write   = 2'b00;
        b_addr    = {5'd0, 5'd3};
        b_req     = 2'b01;
        @(negedge clk);
        check("b_pre_rst_gnt", {30'h0, b_gnt}, 32'h1);
        #1 rst = 1'b1;
        #1 check("b_gnt_in_rst", {30'h0, b_gnt}, 32'h0);
        b_req = 2'b00;
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("b_rdata_after_rst", {24'h0, b_rdata}, 32'h0);
        @(negedge clk);
        check("b_no_rvalid_after_rst", {30'h0, b_rvalid}, 32'h0);
        @(posedge clk); #1;
        b_write = 2'b11;
        b_addr  = {5'd9, 5'd8};
        b_req   = 2'b11;
        @(negedge clk);
        check("b_ptr_after_rst", {30'h0, b_gnt}, 32'h1);
        @(posedge clk); #1;
        b_req = 2'b00;

`ifdef MEM_ARB_PARITY_EN
        b_op(0, 1'b1, 5'd5, 8'h01, 8'h00);
        dut_b.mem_q[5][8] = ~dut_b.mem_q[5][8];
        b_op(0, 1'b0, 5'd5, 8'h00, 8'h01);
        @(negedge clk);
        check("b_perr_forced", {31'h0, b_perr}, 32'h1);
        @(posedge clk); #1;
        b_op(0, 1'b1, 5'd5, 8'h01, 8'h00);
        b_op(0, 1'b0, 5'd5, 8'h00, 8'h01);
        @(negedge clk);
        check("b_perr_clean", {31'h0, b_perr}, 32'h0);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        check("qa_drained", 32'(qa.size()), 32'h0);
        check("qb_drained", 32'(qb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
